// File: rtl/demux8_4b_reg_if.sv
// demux8_4b_reg_if: producer/consumer bus for the
// registered 1-to-8 demux of 4-bit words.
interface demux8_4b_reg_if;
  logic       S2;
  logic       S1;
  logic       S0;
  logic [3:0] W;
  logic       Load;
  logic       AutoSel;
  logic [7:0] Ack;
  logic [3:0] Y0;
  logic [3:0] Y1;
  logic [3:0] Y2;
  logic [3:0] Y3;
  logic [3:0] Y4;
  logic [3:0] Y5;
  logic [3:0] Y6;
  logic [3:0] Y7;
  logic [7:0] V;
  logic [3:0] Count;
  logic       Overrun;
  logic [2:0] Ptr;

  modport master (
    output S2, S1, S0, W, Load, AutoSel, Ack,
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7,
    input  V, Count, Overrun, Ptr
  );

  modport slave (
    input  S2, S1, S0, W, Load, AutoSel, Ack,
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7,
    output V, Count, Overrun, Ptr
  );
endinterface

// File: rtl/demux8_4b_reg.sv
// demux8_4b_reg: registered 1-to-8 demux, 4-bit lanes,
// valid/ack per lane. Option macro: DEMUX_AUTOSEQ_EN.
module demux8_4b_reg (
  input logic            Clock,
  input logic            Resetn,
  demux8_4b_reg_if.slave bus
);
  logic [3:0] y [8];
  logic [7:0] v;
  logic [7:0] v_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       ovr;
  logic [2:0] sel;
  logic [2:0] ptr;
  logic       take;

`ifdef DEMUX_AUTOSEQ_EN
  assign sel = bus.AutoSel ? ptr
             : {bus.S2, bus.S1, bus.S0};

  // round-robin pointer advances on accepted auto loads
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      ptr <= 3'd0;
    else if (take && bus.AutoSel)
      ptr <= ptr + 3'd1;
  end
`else
  logic unused_autosel;
  assign unused_autosel = bus.AutoSel;
  assign sel = {bus.S2, bus.S1, bus.S0};
  assign ptr = 3'd0;
`endif

  assign take = bus.Load
              & (~v[sel] | bus.Ack[sel]);

  // next valid vector (load beats ack) and its popcount
  always_comb begin
    v_nxt = v & ~bus.Ack;
    if (take)
      v_nxt[sel] = 1'b1;
    cnt_nxt = 4'd0;
    for (int i = 0; i < 8; i++)
      cnt_nxt = cnt_nxt + {3'd0, v_nxt[i]};
  end

  // lane registers, flags and status
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++)
        y[i] <= 4'h0;
      v   <= 8'h00;
      cnt <= 4'd0;
      ovr <= 1'b0;
    end else begin
      if (take)
        y[sel] <= bus.W;
      v   <= v_nxt;
      cnt <= cnt_nxt;
      ovr <= bus.Load & ~take;
    end
  end

  assign bus.Y0      = y[0];
  assign bus.Y1      = y[1];
  assign bus.Y2      = y[2];
  assign bus.Y3      = y[3];
  assign bus.Y4      = y[4];
  assign bus.Y5      = y[5];
  assign bus.Y6      = y[6];
  assign bus.Y7      = y[7];
  assign bus.V       = v;
  assign bus.Count   = cnt;
  assign bus.Overrun = ovr;
  assign bus.Ptr     = ptr;
endmodule

// File: tb/tb_demux8_4b_reg.sv
// tb_demux8_4b_reg: random + directed stimulus checked
// against a lane-array model of the demux.
module tb_demux8_4b_reg;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  demux8_4b_reg_if bus ();

  demux8_4b_reg dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  // reference model state
  logic [3:0] my [8];
  bit         mv [8];
  bit         mov = 0;
  int         mptr = 0;

  initial for (int i = 0; i < 8; i++) begin
    my[i] = 4'h0;
    mv[i] = 0;
  end

  function automatic int lane_sel();
`ifdef DEMUX_AUTOSEQ_EN
    if (bus.AutoSel) return mptr;
`endif
    return {bus.S2, bus.S1, bus.S0};
  endfunction

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 8; i++) n += mv[i];
    return n;
  endfunction

  function automatic logic [7:0] mvec();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = mv[i];
    return r;
  endfunction

  function automatic logic [31:0] myvec();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = my[i];
    return r;
  endfunction

  // model: one accepted word per edge, acks clear flags
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) begin
        my[i] = 4'h0;
        mv[i] = 0;
      end
      mov  = 0;
      mptr = 0;
    end else begin
      int s;
      bit ok;
      s   = lane_sel();
      ok  = bus.Load && (!mv[s] || bus.Ack[s]);
      mov = bus.Load && !ok;
      for (int i = 0; i < 8; i++)
        if (bus.Ack[i]) mv[i] = 0;
      if (ok) begin
        my[s] = bus.W;
        mv[s] = 1;
`ifdef DEMUX_AUTOSEQ_EN
        if (bus.AutoSel) mptr = (mptr + 1) % 8;
`endif
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dy();
    return {bus.Y7, bus.Y6, bus.Y5, bus.Y4,
            bus.Y3, bus.Y2, bus.Y1, bus.Y0};
  endfunction

  // every-cycle comparison away from the active edge
  always @(negedge Clock) begin
    chk("Y", dy(), myvec());
    chk("V", {24'd0, bus.V}, {24'd0, mvec()});
    chk("Count", {28'd0, bus.Count}, mcount());
    chk("Overrun", {31'd0, bus.Overrun}, {31'd0, mov});
    chk("Ptr", {29'd0, bus.Ptr}, mptr);
  end

  task automatic cyc(bit ld, logic [2:0] s,
                     logic [3:0] w, logic [7:0] ack,
                     bit auto_s);
    bus.Load = ld;
    {bus.S2, bus.S1, bus.S0} = s;
    bus.W = w;
    bus.Ack = ack;
    bus.AutoSel = auto_s;
    @(posedge Clock);
    #1;
    bus.Load = 0;
    bus.Ack = 8'h00;
    bus.AutoSel = 0;
  endtask

  logic [3:0] yv [8];

  initial begin
    bus.Load = 0;
    bus.S2 = 0;
    bus.S1 = 0;
    bus.S0 = 0;
    bus.W = 4'h0;
    bus.Ack = 8'h00;
    bus.AutoSel = 0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1;
    chk("rst_Y", dy(), 32'h0);
    chk("rst_V", {24'd0, bus.V}, 32'h0);
    chk("rst_Count", {28'd0, bus.Count}, 32'd0);
    chk("rst_Ptr", {29'd0, bus.Ptr}, 32'd0);

    cyc(1, 3'b101, 4'hA, 8'h00, 0);
    chk("route_Y", dy(), 32'h00A0_0000);
    chk("route_V", {24'd0, bus.V}, 32'h20);
    chk("route_Count", {28'd0, bus.Count}, 32'd1);

    cyc(0, 3'd0, 4'h0, 8'h20, 0);
    cyc(1, 3'd2, 4'h3, 8'h00, 0);
    cyc(1, 3'd2, 4'h7, 8'h00, 0);
    chk("ovr_Y2", {28'd0, bus.Y2}, 32'h3);
    chk("ovr_pulse", {31'd0, bus.Overrun}, 32'd1);
    chk("ovr_Count", {28'd0, bus.Count}, 32'd1);
    cyc(0, 3'd0, 4'h0, 8'h00, 0);
    chk("ovr_clear", {31'd0, bus.Overrun}, 32'd0);

    cyc(1, 3'd2, 4'h9, 8'h04, 0);
    chk("sim_Y2", {28'd0, bus.Y2}, 32'h9);
    chk("sim_V", {24'd0, bus.V}, 32'h04);
    chk("sim_Count", {28'd0, bus.Count}, 32'd1);
    chk("sim_ovr", {31'd0, bus.Overrun}, 32'd0);
    cyc(0, 3'd0, 4'h0, 8'hFF, 0);
    chk("ackall_V", {24'd0, bus.V}, 32'h00);
    chk("ackall_Count", {28'd0, bus.Count}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, 3'(i), 4'(i + 1), 8'h00, 0);
      chk("fill_Count", {28'd0, bus.Count}, i + 1);
    end
    chk("fill_V", {24'd0, bus.V}, 32'hFF);
    cyc(1, 3'd3, 4'hE, 8'h00, 0);
    chk("full_ovr", {31'd0, bus.Overrun}, 32'd1);
    chk("full_Y3", {28'd0, bus.Y3}, 32'h4);

    for (int i = 0; i < 10; i++)
      cyc(1, 3'd6, 4'(i), 8'hFF, 1);
`ifdef DEMUX_AUTOSEQ_EN
    chk("auto_Y", dy(), 32'h7654_3298);
    chk("auto_Ptr", {29'd0, bus.Ptr}, 32'd2);
`else
    chk("noauto_Y6", {28'd0, bus.Y6}, 32'h9);
    chk("noauto_Ptr", {29'd0, bus.Ptr}, 32'd0);
`endif
    cyc(0, 3'd0, 4'h0, 8'hFF, 0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0)
          ? 8'($urandom) : 8'h00;
      cyc(1'($urandom_range(0, 3) != 0),
          3'($urandom), 4'($urandom), a,
          1'($urandom));
    end

    for (int i = 0; i < 3; i++)
      cyc(1, 3'(i + 4), 4'hC, 8'h00, 0);
    #2;
    Resetn = 0;
    #1;
    chk("arst_Y", dy(), 32'h0);
    chk("arst_V", {24'd0, bus.V}, 32'h0);
    chk("arst_Count", {28'd0, bus.Count}, 32'd0);
    chk("arst_Ptr", {29'd0, bus.Ptr}, 32'd0);
    @(posedge Clock);
    #1;
    Resetn = 1;
    cyc(1, 3'd1, 4'h5, 8'h00, 0);
    chk("post_Y1", {28'd0, bus.Y1}, 32'h5);
    chk("post_V", {24'd0, bus.V}, 32'h02);

    @(negedge Clock);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
